// File: rtl/vme_pkg.sv
// Shared definitions for the VME register bank blocks.
//   state_e       : access FSM states (idle / wait states / termination)
//   DEF_BASE_ADDR : default byte address of register slot 0
//   idx_w()       : slot-index width for a window of n slots (at least 1 bit)
package vme_pkg;

  localparam logic [15:0] DEF_BASE_ADDR = 16'h7C80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TERM = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vme_addr_dec.sv
// Combinational window decode for a word-aligned VME register bank.
//   addr_i : byte address
//   hit_o  : address is even, inside [BASE_ADDR, BASE_ADDR+2*NREGS) and the
//            slot is implemented in IMPL_MASK
//   idx_o  : slot index (ADDR-BASE_ADDR)>>1, meaningful only when hit_o=1
module vme_addr_dec
  import vme_pkg::*;
#(
  parameter int                AW        = 16,
  parameter logic [AW-1:0]     BASE_ADDR = DEF_BASE_ADDR,
  parameter int                NREGS     = 19,
  parameter logic [NREGS-1:0]  IMPL_MASK = '1,
  localparam int               IW        = idx_w(NREGS)
) (
  input  logic [AW-1:0] addr_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o
);

  // Window span compared one bit wider so BASE_ADDR+2*NREGS may reach 2**AW.
  localparam logic [AW:0] SPAN = (AW+1)'(2 * NREGS);

  logic [AW-1:0]        off;
  logic [(1<<IW)-1:0]   impl_ext;
  logic                 in_rng;

  // Pad the mask to the full index range so out-of-window indices read 0.
  always_comb begin
    impl_ext               = '0;
    impl_ext[NREGS-1:0]    = IMPL_MASK;
  end

  assign off    = addr_i - BASE_ADDR;
  assign in_rng = (addr_i >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign idx_o  = off[IW:1];
  assign hit_o  = ~addr_i[0] & in_rng & impl_ext[idx_o];

endmodule

// File: rtl/vme_regbank_rd.sv
// Handshaked VME slave register bank front end.
//   clk_i/rst_n_i : clock, asynchronous active-low reset
//   stb_i         : access request (level, held until ack_o/berr_o seen)
//   we_i, addr_i, din_i : write enable, byte address, write data (captured
//                   together when the request is accepted)
//   rdata_i       : flattened register sources, slot i at [i*DW +: DW]
//   dout_o        : registered read data, holds last read value
//   ack_o/berr_o  : cycle termination (DTACK / bus error)
//   rd_stb_o/wr_stb_o : one-cycle per-slot pulses, coincident with first ack
//   wdata_o       : latched write data, valid while wr_stb_o pulses
module vme_regbank_rd
  import vme_pkg::*;
#(
  parameter logic [15:0]       BASE_ADDR = DEF_BASE_ADDR,
  parameter int                NREGS     = 19,
  parameter int                DW        = 16,
  parameter int                AW        = 16,
  parameter logic [NREGS-1:0]  IMPL_MASK = 19'h0703FF,
  parameter logic [NREGS-1:0]  SWAP_MASK = '0,
  parameter int                WAIT_CYC  = 1,
  parameter bit                BERR_EN   = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [DW-1:0]        din_i,
  input  logic [NREGS*DW-1:0]  rdata_i,
  output logic [DW-1:0]        dout_o,
  output logic                 ack_o,
  output logic                 berr_o,
  output logic [NREGS-1:0]     rd_stb_o,
  output logic [NREGS-1:0]     wr_stb_o,
  output logic [DW-1:0]        wdata_o
);

  localparam int IW = idx_w(NREGS);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 hit_q, hit_d;
  logic                 we_q, we_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [DW-1:0]        dout_q, dout_d;
  logic                 ack_q, ack_d;
  logic                 berr_q, berr_d;
  logic [NREGS-1:0]     rd_stb_q, rd_stb_d;
  logic [NREGS-1:0]     wr_stb_q, wr_stb_d;

  logic                 dec_hit;
  logic [IW-1:0]        dec_idx;
  logic [DW-1:0]        rd_sel, rd_swp;
  logic                 swp_sel;
  logic [NREGS-1:0]     onehot;

  vme_addr_dec #(
    .AW        (AW),
    .BASE_ADDR (AW'(BASE_ADDR)),
    .NREGS     (NREGS),
    .IMPL_MASK (IMPL_MASK)
  ) u_dec (
    .addr_i (addr_i),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  // Slot select for the captured index: data, swap flag and strobe vector.
  always_comb begin
    rd_sel  = '0;
    swp_sel = 1'b0;
    onehot  = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx_q == IW'(i)) begin
        rd_sel    = rdata_i[i*DW +: DW];
        swp_sel   = SWAP_MASK[i];
        onehot[i] = 1'b1;
      end
    end
    rd_swp = rd_sel;
    for (int b = 0; b < DW/8; b++)
      rd_swp[b*8 +: 8] = rd_sel[(DW/8-1-b)*8 +: 8];
  end

  // TERM is entered with ack/berr still low; that first TERM cycle is the
  // "action" cycle whose closing edge samples RDATA and fires the strobe.
  // This gives ACK WAIT_CYC+1 edges after capture, including WAIT_CYC=0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    we_d     = we_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    ack_d    = ack_q;
    berr_d   = berr_q;
    rd_stb_d = '0;
    wr_stb_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (stb_i) begin
          hit_d = dec_hit;
          idx_d = dec_idx;
          we_d  = we_i;
          if (we_i) wdata_d = din_i;
          if (WAIT_CYC > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYC - 1);
          end else begin
            state_d = ST_TERM;
          end
        end
      end
      ST_WAIT: begin
        if (!stb_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_TERM;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_TERM: begin
        if (!ack_q && !berr_q) begin
          if (!stb_i) begin
            state_d = ST_IDLE;      // master gave up before termination
          end else if (hit_q) begin
            ack_d = 1'b1;
            if (we_q) begin
              wr_stb_d = onehot;
            end else begin
              rd_stb_d = onehot;
              dout_d   = swp_sel ? rd_swp : rd_sel;
            end
          end else begin
            if (BERR_EN) berr_d = 1'b1;
            else         ack_d  = 1'b1;
            if (!we_q) dout_d = '0;
          end
        end else if (!stb_i) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
          berr_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hit_q    <= 1'b0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      dout_q   <= '0;
      ack_q    <= 1'b0;
      berr_q   <= 1'b0;
      rd_stb_q <= '0;
      wr_stb_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      dout_q   <= dout_d;
      ack_q    <= ack_d;
      berr_q   <= berr_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
    end
  end

  assign dout_o   = dout_q;
  assign ack_o    = ack_q;
  assign berr_o   = berr_q;
  assign rd_stb_o = rd_stb_q;
  assign wr_stb_o = wr_stb_q;
  assign wdata_o  = wdata_q;

endmodule

// File: tb/tb_vme_regbank_rd.sv
// Bench for vme_regbank_rd: three instances with different wait-state,
// bus-error and byte-swap settings, each with its own stimulus lane.
//   lane 0: WAIT_CYC=1, BERR_EN=0, SWAP slot 16
//   lane 1: WAIT_CYC=4, BERR_EN=1, no swap
//   lane 2: WAIT_CYC=0, BERR_EN=0, SWAP slots 0 and 2
module tb_vme_regbank_rd;

  localparam int               NREGS = 19;
  localparam int               DW    = 16;
  localparam logic [15:0]      BASE  = 16'h7C80;
  localparam logic [NREGS-1:0] IMPL  = 19'h0703FF;

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 0);
  endfunction
  function automatic logic [NREGS-1:0] swap_of(input int k);
    return (k == 0) ? 19'h10000 : ((k == 2) ? 19'h00005 : 19'h0);
  endfunction

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [2:0]                  stb, we;
  logic [2:0][15:0]            addr, din;
  logic [2:0][NREGS*DW-1:0]    rdata;
  wire  [2:0]                  ack, berr;
  wire  [2:0][15:0]            dout, wdata;
  wire  [2:0][NREGS-1:0]       rd_stb, wr_stb;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_dout [3];

  typedef struct {
    int               lat;
    logic             ack;
    logic             berr;
    logic [15:0]      dout;
    logic [15:0]      wdata;
    logic [15:0]      dout_end;
    logic [NREGS-1:0] rds;
    logic [NREGS-1:0] wrs;
    int               nstb;
    int               ack_cyc;
    int               post_ack;
  } obs_t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vme_regbank_rd #(
      .BASE_ADDR (BASE),
      .NREGS     (NREGS),
      .DW        (DW),
      .AW        (16),
      .IMPL_MASK (IMPL),
      .SWAP_MASK (swap_of(g)),
      .WAIT_CYC  (wait_of(g)),
      .BERR_EN   (g == 1)
    ) u_dut (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .stb_i    (stb[g]),
      .we_i     (we[g]),
      .addr_i   (addr[g]),
      .din_i    (din[g]),
      .rdata_i  (rdata[g]),
      .dout_o   (dout[g]),
      .ack_o    (ack[g]),
      .berr_o   (berr[g]),
      .rd_stb_o (rd_stb[g]),
      .wr_stb_o (wr_stb[g]),
      .wdata_o  (wdata[g])
    );
  end

  // ---------------- reference model (address-window arithmetic) ----------
  function automatic bit m_hit(input logic [15:0] a);
    int ia, lo;
    ia = int'(a);
    lo = int'(BASE);
    if ((ia % 2) != 0 || ia < lo || ia >= lo + 2*NREGS) return 1'b0;
    return IMPL[(ia - lo) / 2];
  endfunction

  function automatic int m_idx(input logic [15:0] a);
    return (int'(a) - int'(BASE)) / 2;
  endfunction

  function automatic logic [15:0] m_slot(input int k, input int idx);
    logic [15:0]      v;
    logic [NREGS-1:0] sm;
    v  = rdata[k][idx*16 +: 16];
    sm = swap_of(k);
    return sm[idx] ? {v[7:0], v[15:8]} : v;
  endfunction

  task automatic rand_rdata(input int k);
    for (int i = 0; i < NREGS; i++) rdata[k][i*16 +: 16] = 16'($urandom);
  endtask

  // Drive one access on lane k and collect what the DUT did. lat counts
  // falling edges after the capture edge (1 = right after capture), so an
  // ACK after capture edge + WAIT_CYC + 1 shows up as lat = WAIT_CYC + 2.
  task automatic run_access(input int k, input bit w, input logic [15:0] a,
                            input logic [15:0] d, input int hold, output obs_t o);
    int cyc;
    o.lat = -1; o.ack = 0; o.berr = 0; o.dout = '0; o.wdata = '0; o.dout_end = '0;
    o.rds = '0; o.wrs = '0; o.nstb = 0; o.ack_cyc = 0; o.post_ack = 0;
    @(negedge clk);
    we[k] = w; addr[k] = a; din[k] = d; stb[k] = 1'b1;
    cyc = 0;
    while (o.lat < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      o.nstb += $countones(rd_stb[k]) + $countones(wr_stb[k]);
      if (ack[k] || berr[k]) begin
        o.lat = cyc; o.ack = ack[k]; o.berr = berr[k]; o.dout = dout[k];
        o.wdata = wdata[k]; o.rds = rd_stb[k]; o.wrs = wr_stb[k]; o.ack_cyc = 1;
      end else begin
        // bus lines wander after capture; the DUT must ignore them
        addr[k] = 16'($urandom); we[k] = 1'($urandom); din[k] = 16'($urandom);
      end
    end
    for (int h = 0; h < hold && o.lat >= 0; h++) begin
      rand_rdata(k);
      @(negedge clk);
      o.nstb += $countones(rd_stb[k]) + $countones(wr_stb[k]);
      if (ack[k] || berr[k]) o.ack_cyc++;
    end
    o.dout_end = dout[k];
    stb[k] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      o.nstb += $countones(rd_stb[k]) + $countones(wr_stb[k]);
      if (ack[k] || berr[k]) o.post_ack++;
    end
  endtask

  // ---------------- tests -------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; stb = '0; we = '0; addr = '0; din = '0; rdata = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({ack[k], berr[k], dout[k], wdata[k], rd_stb[k], wr_stb[k]} !== '0) begin
        n_fail++;
        $display("FAIL reset_outs lane%0d: got ack=%b berr=%b dout=%h wdata=%h rd=%h wr=%h exp all 0",
                 k, ack[k], berr[k], dout[k], wdata[k], rd_stb[k], wr_stb[k]);
      end
      exp_dout[k] = '0;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_basic();
    obs_t o;
    rand_rdata(0);
    rdata[0][3*16 +: 16] = 16'h1234;
    run_access(0, 1'b0, 16'h7C86, 16'($urandom), 0, o);
    n_tests++; if (o.lat !== 3) begin n_fail++; $display("FAIL rd_lat: got %0d exp 3", o.lat); end
    n_tests++; if ({o.ack, o.berr} !== 2'b10) begin n_fail++; $display("FAIL rd_term: got ack=%b berr=%b exp 1/0", o.ack, o.berr); end
    n_tests++; if (o.dout !== 16'h1234) begin n_fail++; $display("FAIL rd_dout: got %h exp 1234", o.dout); end
    n_tests++; if (o.rds !== 19'h8 || o.wrs !== 19'h0) begin n_fail++; $display("FAIL rd_stb: got rd=%h wr=%h exp 00008/0", o.rds, o.wrs); end
    n_tests++; if (o.nstb !== 1 || o.post_ack !== 0) begin n_fail++; $display("FAIL rd_once: got strobes=%0d post_ack=%0d exp 1/0", o.nstb, o.post_ack); end
    exp_dout[0] = 16'h1234;
  endtask

  task automatic test_write();
    obs_t o;
    run_access(0, 1'b1, 16'h7CA2, 16'hBEEF, 0, o);
    n_tests++; if (o.lat !== 3 || o.ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got lat=%0d ack=%b exp 3/1", o.lat, o.ack); end
    n_tests++; if (o.wrs !== 19'h20000 || o.rds !== 19'h0) begin n_fail++; $display("FAIL wr_stb: got wr=%h rd=%h exp 20000/0", o.wrs, o.rds); end
    n_tests++; if (o.wdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_data: got %h exp beef", o.wdata); end
    n_tests++; if (o.dout !== exp_dout[0]) begin n_fail++; $display("FAIL wr_dout_kept: got %h exp %h", o.dout, exp_dout[0]); end
    n_tests++; if (o.nstb !== 1) begin n_fail++; $display("FAIL wr_once: got %0d strobes exp 1", o.nstb); end
  endtask

  task automatic test_miss();
    obs_t o;
    logic [15:0] miss_a [3];
    miss_a[0] = 16'h7C98; miss_a[1] = 16'h7C81; miss_a[2] = 16'h7D00;
    for (int i = 0; i < 3; i++) begin
      rand_rdata(0);
      run_access(0, 1'b0, miss_a[i], 16'h0, 0, o);
      n_tests++;
      if (o.lat !== 3 || {o.ack, o.berr} !== 2'b10 || o.dout !== 16'h0 || o.nstb !== 0) begin
        n_fail++;
        $display("FAIL miss_ack %h: got lat=%0d ack=%b berr=%b dout=%h strobes=%0d exp 3/1/0/0000/0",
                 miss_a[i], o.lat, o.ack, o.berr, o.dout, o.nstb);
      end
      exp_dout[0] = '0;
      rand_rdata(1);
      run_access(1, 1'b0, miss_a[i], 16'h0, 0, o);
      n_tests++;
      if (o.lat !== 6 || {o.ack, o.berr} !== 2'b01 || o.dout !== 16'h0 || o.nstb !== 0) begin
        n_fail++;
        $display("FAIL miss_berr %h: got lat=%0d ack=%b berr=%b dout=%h strobes=%0d exp 6/0/1/0000/0",
                 miss_a[i], o.lat, o.ack, o.berr, o.dout, o.nstb);
      end
      exp_dout[1] = '0;
    end
    // write miss: bus error, no strobe, read data register untouched
    rdata[1][0 +: 16] = 16'h5A5A;
    run_access(1, 1'b0, 16'h7C80, 16'h0, 0, o);
    exp_dout[1] = 16'h5A5A;
    run_access(1, 1'b1, 16'h7C9C, 16'h1111, 0, o);
    n_tests++;
    if (o.berr !== 1'b1 || o.nstb !== 0 || o.dout !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL wr_miss: got berr=%b strobes=%0d dout=%h exp 1/0/5a5a", o.berr, o.nstb, o.dout);
    end
  endtask

  task automatic test_swap();
    obs_t o;
    rand_rdata(0);
    rdata[0][16*16 +: 16] = 16'hA855;
    run_access(0, 1'b0, 16'h7CA0, 16'h0, 0, o);
    n_tests++; if (o.dout !== 16'h55A8 || o.rds !== 19'h10000) begin n_fail++; $display("FAIL swap: got dout=%h rd=%h exp 55a8/10000", o.dout, o.rds); end
    exp_dout[0] = 16'h55A8;
  endtask

  task automatic test_wait0();
    obs_t o;
    rand_rdata(2);
    rdata[2][2*16 +: 16] = 16'h1200;
    run_access(2, 1'b0, 16'h7C84, 16'h0, 0, o);
    n_tests++; if (o.lat !== 2) begin n_fail++; $display("FAIL wait0_lat: got %0d exp 2", o.lat); end
    n_tests++; if (o.dout !== 16'h0012 || o.rds !== 19'h4) begin n_fail++; $display("FAIL wait0_swap: got dout=%h rd=%h exp 0012/00004", o.dout, o.rds); end
    exp_dout[2] = 16'h0012;
  endtask

  task automatic test_abort();
    obs_t o;
    int seen;
    rand_rdata(1);
    @(negedge clk);
    stb[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h7C80;
    repeat (2) @(negedge clk);
    stb[1] = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen += int'(ack[1]) + int'(berr[1]) + $countones(rd_stb[1]) + $countones(wr_stb[1]);
    end
    n_tests++; if (seen !== 0 || dout[1] !== exp_dout[1]) begin n_fail++; $display("FAIL abort: got events=%0d dout=%h exp 0/%h", seen, dout[1], exp_dout[1]); end
    rdata[1][1*16 +: 16] = 16'h7E57;
    run_access(1, 1'b0, 16'h7C82, 16'h0, 0, o);
    n_tests++; if (o.lat !== 6 || o.rds !== 19'h2 || o.dout !== 16'h7E57) begin n_fail++; $display("FAIL abort_next: got lat=%0d rd=%h dout=%h exp 6/00002/7e57", o.lat, o.rds, o.dout); end
    exp_dout[1] = 16'h7E57;
  endtask

  task automatic test_hold();
    obs_t o;
    logic [15:0] e;
    rand_rdata(0);
    e = m_slot(0, 0);
    run_access(0, 1'b0, 16'h7C80, 16'h0, 3, o);
    n_tests++; if (o.ack_cyc !== 4 || o.post_ack !== 0) begin n_fail++; $display("FAIL hold_ack: got ack_cycles=%0d post=%0d exp 4/0", o.ack_cyc, o.post_ack); end
    n_tests++; if (o.dout_end !== e || o.nstb !== 1) begin n_fail++; $display("FAIL hold_dout: got dout=%h strobes=%0d exp %h/1", o.dout_end, o.nstb, e); end
    exp_dout[0] = e;
  endtask

  task automatic test_reset_mid();
    int cyc, ns, lat;
    rand_rdata(1);
    rdata[1][5*16 +: 16] = 16'hC0DE;
    @(negedge clk);
    stb[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h7C8A;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; #1;
    n_tests++;
    if ({ack[1], berr[1], rd_stb[1], wr_stb[1], dout[1]} !== '0) begin
      n_fail++; $display("FAIL rst_in_wait: got ack=%b berr=%b rd=%h dout=%h exp all 0", ack[1], berr[1], rd_stb[1], dout[1]);
    end
    for (int k = 0; k < 3; k++) exp_dout[k] = '0;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      rst_n = 1'b1;                         // stb stays high across release
      cyc = 0; ns = 0; lat = -1;
      while (lat < 0 && cyc < 40) begin
        @(negedge clk);
        cyc++;
        ns += $countones(rd_stb[1]) + $countones(wr_stb[1]);
        if (ack[1]) lat = cyc;
      end
      n_tests++;
      if (lat !== 6 || ns !== 1 || dout[1] !== 16'hC0DE || rd_stb[1] !== 19'h20) begin
        n_fail++; $display("FAIL rst_fresh%0d: got lat=%0d strobes=%0d dout=%h rd=%h exp 6/1/c0de/00020", pass, lat, ns, dout[1], rd_stb[1]);
      end
      if (pass == 0) begin
        rst_n = 1'b0; #1;                   // reset during the ACK cycle
        n_tests++;
        if ({ack[1], berr[1], rd_stb[1], dout[1]} !== '0) begin
          n_fail++; $display("FAIL rst_in_term: got ack=%b rd=%h dout=%h exp all 0", ack[1], rd_stb[1], dout[1]);
        end
      end
    end
    stb[1] = 1'b0;
    repeat (2) @(negedge clk);
    exp_dout[1] = 16'hC0DE;
  endtask

  task automatic test_random();
    obs_t o;
    int k, r, idx;
    bit w, hit;
    logic [15:0] a, d, e_dout;
    logic [NREGS-1:0] e_vec;
    for (int it = 0; it < 60; it++) begin
      k = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r == 0)      a = 16'h7D00;
      else if (r == 1) a = BASE - 16'd2;
      else             a = BASE + 16'($urandom_range(0, 2*NREGS + 3));
      w = 1'($urandom);
      d = 16'($urandom);
      rand_rdata(k);
      hit = m_hit(a);
      idx = hit ? m_idx(a) : 0;
      e_vec = hit ? (NREGS'(1) << idx) : '0;
      e_dout = w ? exp_dout[k] : (hit ? m_slot(k, idx) : 16'h0);
      run_access(k, w, a, d, 0, o);
      n_tests++;
      if (o.lat !== wait_of(k) + 2 || o.ack !== (hit || k != 1) || o.berr !== (!hit && k == 1)) begin
        n_fail++; $display("FAIL rnd_term l%0d a=%h we=%0d: got lat=%0d ack=%b berr=%b exp lat=%0d hit=%0d",
                           k, a, w, o.lat, o.ack, o.berr, wait_of(k) + 2, hit);
      end
      n_tests++;
      if (o.dout !== e_dout || o.rds !== (w ? '0 : e_vec) || o.wrs !== (w ? e_vec : '0) || o.nstb !== int'(hit)) begin
        n_fail++; $display("FAIL rnd_data l%0d a=%h we=%0d: got dout=%h rd=%h wr=%h n=%0d exp dout=%h vec=%h",
                           k, a, w, o.dout, o.rds, o.wrs, o.nstb, e_dout, e_vec);
      end
      if (hit && w) begin
        n_tests++;
        if (o.wdata !== d) begin n_fail++; $display("FAIL rnd_wdata l%0d: got %h exp %h", k, o.wdata, d); end
      end
      exp_dout[k] = e_dout;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_basic();
    test_write();
    test_miss();
    test_swap();
    test_wait0();
    test_abort();
    test_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
